// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: the canonical NOP, the default reset PC,
// the instruction field positions the control unit decodes, and the fetch FSM states.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
// A flush empties it in one cycle. Push and pop may happen together at any fill level.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign empty  = (count == '0);
    assign full   = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign rdata  = mem[rd_ptr];

    // Storage array: written on every push, no reset needed since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both return to empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: issues word requests at the fetch PC, buffers in-order
// responses tagged with their PC, and presents the FIFO head to the decode/control logic.
// A taken branch flushes the buffer and drops every response still in flight.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [6:0]      Op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [XLEN-1:0]  fpc;
    logic [XLEN-1:0]  pc_tag;
    logic [XLEN-1:0]  target;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    outstanding_next;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    drop_next;
    logic [CW-1:0]    count;
    logic [CW:0]      credit_used;
    logic             req_fire;
    logic             pop;
    logic             redirect;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [XLEN+31:0] head;

    // Buffered entries plus in-flight requests may never exceed the FIFO depth,
    // which guarantees every response has a slot waiting for it.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && (credit_used < DEPTH_C);
    assign imem_req_addr  = fpc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign pop      = instr_valid && instr_ready;
    assign redirect = pop && PCSrc;
    assign target   = {PCTarget[XLEN-1:2], 2'b00};
    assign push     = imem_rsp_valid && (state == RUN) && !redirect;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({pc_tag, imem_rsp_data}),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign Instr       = instr_valid ? head[31:0] : NOP_INSTR;
    assign PC          = instr_valid ? head[XLEN+31:32] : pc_tag;
    assign PCPlus4     = PC + PC_STEP;
    assign Op          = Instr[OP_MSB:OP_LSB];
    assign funct3      = Instr[F3_MSB:F3_LSB];
    assign funct7      = Instr[F7_MSB:F7_LSB];

    // In-flight count: up on an accepted request, down on any returning response.
    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    // Responses to discard: a redirect marks everything still in flight as stale.
    always_comb begin
        drop_next = drop_cnt;
        if (redirect) begin
            drop_next = outstanding_next;
        end else if (imem_rsp_valid && (state == FLUSH)) begin
            drop_next = drop_cnt - 1'b1;
        end
    end

    // FLUSH lasts exactly as long as stale responses remain to be discarded.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (drop_next != '0) state_next = FLUSH;
            FLUSH:   if (drop_next == '0) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Fetch PC, response tag PC and the two response counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc         <= RESET_PC;
            pc_tag      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
            if (redirect) begin
                fpc    <= target;
                pc_tag <= target;
            end else begin
                if (req_fire) begin
                    fpc <= fpc + PC_STEP;
                end
                if (push) begin
                    pc_tag <= pc_tag + PC_STEP;
                end
            end
        end
    end

    // The credit scheme must make pushing into a full buffer impossible.
    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order instruction memory model and a
// reference PC model that predicts every delivered {PC, Instr} pair.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [6:0]  Op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'h0;

    int          testCount = 0;
    int          failCount = 0;
    int          cyc = 0;
    int          latMin = 1;
    int          latMax = 1;
    bit          randReady = 1'b0;
    logic [31:0] expPc = 32'h0;

    memReq_t     memQ[$];
    logic [31:0] acceptAddr[$];
    int          acceptCyc[$];
    logic [31:0] popPc[$];
    int          popCyc[$];

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .Instr          (Instr),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .Op             (Op),
        .funct3         (funct3),
        .funct7         (funct7),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h5A3C_0000;
    endfunction

    // In-order memory: accepts on handshake, answers after a per-request latency.
    always @(posedge clk) begin
        if (rst) begin
            memQ.delete();
        end else begin
            if (imem_rsp_valid) begin
                void'(memQ.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                memQ.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(latMax, latMin))});
                acceptAddr.push_back(imem_req_addr);
                acceptCyc.push_back(cyc);
            end
        end
        cyc = cyc + 1;
        #1;
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(memQ[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        imem_req_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drives the core-side inputs and scores any pop against the model.
    task automatic applyStimulus(input logic rdy, input logic src, input logic [31:0] tgt);
        logic [31:0] expInstr;
        logic [31:0] expPc4;
        instr_ready = rdy;
        PCSrc       = src;
        PCTarget    = tgt;
        if (instr_valid && rdy) begin
            expInstr = memWord(expPc);
            expPc4   = expPc + 32'd4;
            checkOutput("pop_pc", PC, expPc);
            checkOutput("pop_instr", Instr, expInstr);
            checkOutput("pop_pcplus4", PCPlus4, expPc4);
            checkOutput("pop_op", 32'(Op), 32'(expInstr[6:0]));
            checkOutput("pop_funct3", 32'(funct3), 32'(expInstr[14:12]));
            checkOutput("pop_funct7", 32'(funct7), 32'(expInstr[31:25]));
            popPc.push_back(PC);
            popCyc.push_back(cyc);
            expPc = src ? (tgt & ~32'h3) : expPc4;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst         = 1'b1;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        @(negedge clk);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_instr", Instr, 32'h0000_0013);
        checkOutput("rst_pc", PC, 32'h0);
        checkOutput("rst_pcplus4", PCPlus4, 32'h4);
        checkOutput("rst_req_addr", imem_req_addr, 32'h0);
        rst   = 1'b0;
        expPc = 32'h0;
        acceptAddr.delete();
        acceptCyc.delete();
        popPc.delete();
        popCyc.delete();
    endtask

    task automatic popNext(input string tag, output logic [31:0] pc, output logic [31:0] pc4);
        bit got = 1'b0;
        pc  = 32'h0;
        pc4 = 32'h0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                got = 1'b1;
                pc  = PC;
                pc4 = PCPlus4;
            end
            applyStimulus(1'b1, 1'b0, 32'h0);
        end
        checkOutput(tag, 32'(got), 32'd1);
    endtask

    task automatic redirectNext(input string tag, input logic [31:0] tgt);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                got = 1'b1;
                applyStimulus(1'b1, 1'b1, tgt);
            end else begin
                applyStimulus(1'b1, 1'b0, 32'h0);
            end
        end
        checkOutput({tag, "_found"}, 32'(got), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_addr"}, imem_req_addr, tgt & ~32'h3);
        applyStimulus(1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        rdy;
        logic        src;
        logic [31:0] tgt;
        int          firstValid;
        bit          found;

        // Test 1: 1-cycle memory, core always ready.
        latMin = 1;
        latMax = 1;
        doReset();
        firstValid = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (instr_valid && firstValid < 0) firstValid = cyc;
            applyStimulus(1'b1, 1'b0, 32'h0);
        end
        checkOutput("t1_accepts", 32'(acceptAddr.size() >= 4), 32'd1);
        if (acceptAddr.size() >= 4) begin
            for (int i = 0; i < 4; i++) checkOutput("t1_req_addr", acceptAddr[i], 32'(4 * i));
            checkOutput("t1_first_latency", 32'(firstValid - acceptCyc[0]), 32'd2);
        end
        checkOutput("t1_pops", 32'(popPc.size() >= 4), 32'd1);

        // Test 2: core stalled, credits cap issue at DEPTH, then drain back to back.
        doReset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("t2_accepts", 32'(acceptAddr.size()), 32'(DEPTH));
        checkOutput("t2_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("t2_instr_valid", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 32'h0);
        end
        checkOutput("t2_drain_pops", 32'(popCyc.size() >= 4), 32'd1);
        if (popCyc.size() >= 4) checkOutput("t2_no_gap", 32'(popCyc[3] - popCyc[0]), 32'd3);

        // Test 3: redirect at PC 0x8 to 0x40 with two requests in flight.
        latMin = 3;
        latMax = 3;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (instr_valid && PC == 32'h8) begin
                found = 1'b1;
                applyStimulus(1'b1, 1'b1, 32'h40);
            end else begin
                applyStimulus(1'b1, 1'b0, 32'h0);
            end
        end
        checkOutput("t3_found", 32'(found), 32'd1);
        @(negedge clk);
        checkOutput("t3_state_flush", 32'(dut.state), 32'(FLUSH));
        checkOutput("t3_drop_cnt", 32'(dut.drop_cnt), 32'd2);
        checkOutput("t3_empty", 32'(instr_valid), 32'd0);
        checkOutput("t3_empty_pc", PC, 32'h40);
        checkOutput("t3_req_addr", imem_req_addr, 32'h40);
        applyStimulus(1'b1, 1'b0, 32'h0);
        popNext("t3_refill", pc, pc4);
        checkOutput("t3_target_pc", pc, 32'h40);
        checkOutput("t3_state_run", 32'(dut.state), 32'(RUN));

        // Test 4: target alignment and PC wrap.
        redirectNext("t4_mask", 32'h43);
        popNext("t4_mask_pop", pc, pc4);
        checkOutput("t4_mask_pc", pc, 32'h40);
        redirectNext("t4_wrap", 32'hFFFF_FFFF);
        popNext("t4_wrap_pop0", pc, pc4);
        checkOutput("t4_wrap_pc0", pc, 32'hFFFF_FFFC);
        checkOutput("t4_wrap_pc4", pc4, 32'h0);
        popNext("t4_wrap_pop1", pc, pc4);
        checkOutput("t4_wrap_pc1", pc, 32'h0);

        // Test 5: reset with the buffer occupied and requests in flight.
        doReset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("t5_buffered", 32'(instr_valid), 32'd1);
        doReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("t5_restart", 32'(acceptAddr.size() >= 1), 32'd1);
        if (acceptAddr.size() >= 1) checkOutput("t5_restart_addr", acceptAddr[0], 32'h0);
        popNext("t5_pop", pc, pc4);
        checkOutput("t5_pop_pc", pc, 32'h0);

        // Test 6: random latency, memory backpressure, core stalls and redirects.
        latMin    = 1;
        latMax    = 4;
        randReady = 1'b1;
        doReset();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rdy = ($urandom_range(0, 3) != 0);
            src = ($urandom_range(0, 15) == 0);
            tgt = $urandom;
            applyStimulus(rdy, src, tgt);
        end
        checkOutput("t6_progress", 32'(popPc.size() > 50), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
